// File: rtl/cp0_interrupt_unit_pkg.sv
// Shared constants and helpers for the CP0 interrupt unit: register numbers,
// Status/Cause bit positions and the default exception handler address.
package cp0_interrupt_unit_pkg;

  localparam int unsigned REGNUM_W   = 5;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned IM_W       = 8;
  localparam int unsigned MAX_EXT    = 5;

  localparam logic [REGNUM_W-1:0] CP0_STATUS = 5'd12;
  localparam logic [REGNUM_W-1:0] CP0_CAUSE  = 5'd13;
  localparam logic [REGNUM_W-1:0] CP0_EPC    = 5'd14;

  localparam int unsigned STATUS_IE    = 0;
  localparam int unsigned STATUS_EXL   = 1;
  localparam int unsigned IM_LSB       = 8;
  localparam int unsigned IM_MSB       = 15;
  localparam int unsigned EXT_IP_LSB   = 10;
  localparam int unsigned TIMER_IP_BIT = 15;

  localparam logic [WORD_W-1:0] DEFAULT_HANDLER_PC = 32'h8000_0180;

  // Architectural view of Status built from the three stored fields.
  function automatic logic [WORD_W-1:0] packStatus(input logic [IM_W-1:0] im,
                                                   input logic exl,
                                                   input logic ie);
    logic [WORD_W-1:0] s;
    s = '0;
    s[IM_MSB:IM_LSB] = im;
    s[STATUS_EXL]    = exl;
    s[STATUS_IE]     = ie;
    return s;
  endfunction

  // Cause only carries the pending-interrupt field; ExcCode stays zero.
  function automatic logic [WORD_W-1:0] packCause(input logic [IM_W-1:0] ip);
    logic [WORD_W-1:0] c;
    c = '0;
    c[IM_MSB:IM_LSB] = ip;
    return c;
  endfunction

endpackage

// File: rtl/cp0_interrupt_unit_register.sv
// Generic enabled register with asynchronous active-high reset to a
// parameterised value; the storage primitive used for all CP0 state.
module cp0_register #(
  parameter int unsigned           WIDTH       = 32,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/cp0_interrupt_unit.sv
// Coprocessor-0 interrupt unit: Status/Cause/EPC, mfc0/mtc0/eret handling and
// the combinational decision to redirect the PC to the interrupt handler.
module cp0_interrupt_unit
  import cp0_interrupt_unit_pkg::*;
#(
  parameter int unsigned        NUM_EXT    = 5,
  parameter logic [WORD_W-1:0]  HANDLER_PC = DEFAULT_HANDLER_PC
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [REGNUM_W-1:0] regnum,
  input  logic [WORD_W-1:0]   wr_data,
  input  logic                MTC0,
  input  logic                ERET,
  input  logic [WORD_W-1:0]   next_pc,
  input  logic                TimerInterrupt,
  input  logic [NUM_EXT-1:0]  ExtInterrupt,
  output logic [WORD_W-1:0]   rd_data,
  output logic [WORD_W-1:0]   EPC,
  output logic                TakenInterrupt,
  output logic [WORD_W-1:0]   handler_pc
);

  logic [MAX_EXT-1:0] extPadded;
  logic [IM_W-1:0]    pending;
  logic [IM_W-1:0]    imQ;
  logic               exlQ;
  logic               ieQ;
  logic               takenC;

  logic               writeStatus;
  logic               writeEpc;
  logic               epcEn;
  logic [WORD_W-1:0]  epcD;
  logic               imEn;
  logic [IM_W-1:0]    imD;
  logic               exlEn;
  logic               exlD;
  logic               ieEn;
  logic               ieD;

  assign handler_pc = HANDLER_PC;

  // Interrupt lines are live: IP7 is the timer, IP6..IP2 the external lines.
  assign extPadded = MAX_EXT'(ExtInterrupt);
  assign pending   = {TimerInterrupt, extPadded, 2'b00};

  // Reset gating makes the redirect drop the instant reset rises.
  assign takenC         = ~reset & ieQ & ~exlQ & (|(pending & imQ));
  assign TakenInterrupt = takenC;

  // A taken interrupt squashes the instruction, so its mtc0/eret are dropped.
  always_comb begin
    writeStatus = 1'b0;
    writeEpc    = 1'b0;
    epcEn       = 1'b0;
    epcD        = wr_data;
    imEn        = 1'b0;
    imD         = wr_data[IM_MSB:IM_LSB];
    ieEn        = 1'b0;
    ieD         = wr_data[STATUS_IE];
    exlEn       = 1'b0;
    exlD        = wr_data[STATUS_EXL];

    if (takenC) begin
      epcEn = 1'b1;
      epcD  = next_pc;
      exlEn = 1'b1;
      exlD  = 1'b1;
    end else begin
      writeStatus = MTC0 && (regnum == CP0_STATUS);
      writeEpc    = MTC0 && (regnum == CP0_EPC);
      epcEn       = writeEpc;
      imEn        = writeStatus;
      ieEn        = writeStatus;
      exlEn       = writeStatus;
      // eret wins over a simultaneous Status write for EXL only.
      if (ERET) begin
        exlEn = 1'b1;
        exlD  = 1'b0;
      end
    end
  end

  cp0_register #(.WIDTH(WORD_W), .RESET_VALUE('0)) uEpc (
    .clock  (clock),
    .reset  (reset),
    .enable (epcEn),
    .d      (epcD),
    .q      (EPC)
  );

  cp0_register #(.WIDTH(IM_W), .RESET_VALUE('0)) uIm (
    .clock  (clock),
    .reset  (reset),
    .enable (imEn),
    .d      (imD),
    .q      (imQ)
  );

  cp0_register #(.WIDTH(1), .RESET_VALUE(1'b0)) uExl (
    .clock  (clock),
    .reset  (reset),
    .enable (exlEn),
    .d      (exlD),
    .q      (exlQ)
  );

  cp0_register #(.WIDTH(1), .RESET_VALUE(1'b0)) uIe (
    .clock  (clock),
    .reset  (reset),
    .enable (ieEn),
    .d      (ieD),
    .q      (ieQ)
  );

  // mfc0 read mux; unmapped register numbers read as zero.
  always_comb begin
    rd_data = '0;
    unique case (regnum)
      CP0_STATUS: rd_data = packStatus(imQ, exlQ, ieQ);
      CP0_CAUSE:  rd_data = packCause(pending);
      CP0_EPC:    rd_data = EPC;
      default:    rd_data = '0;
    endcase
  end

endmodule
